// File: rtl/alarm_clock_multi.sv
// 24-hour time-of-day clock with a 1 Hz prescaler and NUM_ALARMS programmable alarms with
// snooze, dismiss and buzzer auto-timeout. `define ALARM_CLOCK_12H_EN adds a 12-hour display view.
module alarm_clock_multi #(
  parameter int unsigned TICKS_PER_SEC = 100000000,
  parameter int unsigned NUM_ALARMS    = 4,
  parameter int unsigned BUZZ_SECS     = 60,
  parameter int unsigned SNOOZE_SECS   = 300
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic                                                  start,
  input  logic                                                  load_time,
  input  logic [4:0]                                            load_h,
  input  logic [5:0]                                            load_m,
  input  logic [5:0]                                            load_s,
  input  logic                                                  alarm_wr,
  input  logic [(NUM_ALARMS > 1 ? $clog2(NUM_ALARMS) : 1)-1:0]  alarm_idx,
  input  logic [4:0]                                            alarm_h,
  input  logic [5:0]                                            alarm_m,
  input  logic [5:0]                                            alarm_s,
  input  logic                                                  alarm_en,
  input  logic                                                  snooze,
  input  logic                                                  dismiss,
  output logic [4:0]                                            hours,
  output logic [5:0]                                            mins,
  output logic [5:0]                                            secs,
  output logic                                                  sec_pulse,
  output logic                                                  buzzer,
  output logic [(NUM_ALARMS > 1 ? $clog2(NUM_ALARMS) : 1)-1:0]  ring_idx,
`ifdef ALARM_CLOCK_12H_EN
  output logic [3:0]                                            disp_hours,
  output logic                                                  pm,
`endif
  output logic                                                  load_err
);

  localparam int unsigned IDXW    = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
  localparam int unsigned PW      = $clog2(TICKS_PER_SEC);
  localparam int unsigned CNT_MAX = (BUZZ_SECS > SNOOZE_SECS) ? BUZZ_SECS : SNOOZE_SECS;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StRing   = 2'd1;
  localparam logic [1:0] StSnooze = 2'd2;

  logic [PW-1:0]   presc_q, presc_d;
  logic [4:0]      hours_q, hours_d;
  logic [5:0]      mins_q, mins_d;
  logic [5:0]      secs_q, secs_d;
  logic            sec_pulse_q;
  logic            load_err_q;
  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IDXW-1:0] ring_idx_q, ring_idx_d;

  logic [4:0] slot_h_q  [NUM_ALARMS];
  logic [5:0] slot_m_q  [NUM_ALARMS];
  logic [5:0] slot_s_q  [NUM_ALARMS];
  logic       slot_en_q [NUM_ALARMS];

  logic       tick, inc, load_ok, alarm_ok, alarm_bad;
  logic [4:0] hours_inc;
  logic [5:0] mins_inc, secs_inc;
  logic       any_match;
  logic [IDXW-1:0] match_idx;

  // ---------------------------------------------------------------------------
  // Strobe qualification
  // ---------------------------------------------------------------------------
  assign tick      = start && (presc_q == PW'(TICKS_PER_SEC - 1));
  assign load_ok   = load_time && (load_h <= 5'd23) && (load_m <= 6'd59) && (load_s <= 6'd59);
  assign alarm_bad = (alarm_h > 5'd23) || (alarm_m > 6'd59) || (alarm_s > 6'd59) ||
                     (32'(alarm_idx) >= NUM_ALARMS);
  assign alarm_ok  = alarm_wr && !alarm_bad;
  // An accepted load swallows a coincident second increment.
  assign inc       = tick && !load_ok;

  // ---------------------------------------------------------------------------
  // Time of day
  // ---------------------------------------------------------------------------
  always_comb begin
    secs_inc  = secs_q + 6'd1;
    mins_inc  = mins_q;
    hours_inc = hours_q;
    if (secs_q == 6'd59) begin
      secs_inc = 6'd0;
      mins_inc = mins_q + 6'd1;
      if (mins_q == 6'd59) begin
        mins_inc  = 6'd0;
        hours_inc = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
      end
    end
  end

  always_comb begin
    presc_d = presc_q;
    hours_d = hours_q;
    mins_d  = mins_q;
    secs_d  = secs_q;
    if (load_ok) begin
      presc_d = '0;
      hours_d = load_h;
      mins_d  = load_m;
      secs_d  = load_s;
    end else if (start) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        hours_d = hours_inc;
        mins_d  = mins_inc;
        secs_d  = secs_inc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Alarm compare against the time being entered on this edge; lowest index wins
  // ---------------------------------------------------------------------------
  always_comb begin
    any_match = 1'b0;
    match_idx = '0;
    for (int i = int'(NUM_ALARMS) - 1; i >= 0; i--) begin
      if (slot_en_q[i] && (slot_h_q[i] == hours_inc) && (slot_m_q[i] == mins_inc) &&
          (slot_s_q[i] == secs_inc)) begin
        any_match = 1'b1;
        match_idx = IDXW'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Ring FSM; cnt counts second increments while ringing or snoozed
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ring_idx_d = ring_idx_q;
    case (state_q)
      StIdle: begin
        if (inc && any_match) begin
          state_d    = StRing;
          cnt_d      = '0;
          ring_idx_d = match_idx;
        end
      end
      StRing: begin
        if (dismiss) begin
          state_d = StIdle;
        end else if (snooze) begin
          state_d = StSnooze;
          cnt_d   = '0;
        end else if (inc) begin
          if (cnt_q == CW'(BUZZ_SECS - 1)) state_d = StIdle;
          else                              cnt_d   = cnt_q + CW'(1);
        end
      end
      StSnooze: begin
        if (dismiss) begin
          state_d = StIdle;
        end else if (inc) begin
          if (cnt_q == CW'(SNOOZE_SECS - 1)) begin
            state_d = StRing;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q     <= '0;
      hours_q     <= '0;
      mins_q      <= '0;
      secs_q      <= '0;
      sec_pulse_q <= 1'b0;
      load_err_q  <= 1'b0;
      state_q     <= StIdle;
      cnt_q       <= '0;
      ring_idx_q  <= '0;
    end else begin
      presc_q     <= presc_d;
      hours_q     <= hours_d;
      mins_q      <= mins_d;
      secs_q      <= secs_d;
      sec_pulse_q <= inc;
      load_err_q  <= (load_time && !load_ok) || (alarm_wr && alarm_bad);
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ring_idx_q  <= ring_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_ALARMS); i++) begin
        slot_h_q[i]  <= '0;
        slot_m_q[i]  <= '0;
        slot_s_q[i]  <= '0;
        slot_en_q[i] <= 1'b0;
      end
    end else if (alarm_ok) begin
      slot_h_q[alarm_idx]  <= alarm_h;
      slot_m_q[alarm_idx]  <= alarm_m;
      slot_s_q[alarm_idx]  <= alarm_s;
      slot_en_q[alarm_idx] <= alarm_en;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign hours     = hours_q;
  assign mins      = mins_q;
  assign secs      = secs_q;
  assign sec_pulse = sec_pulse_q;
  assign buzzer    = (state_q == StRing);
  assign ring_idx  = ring_idx_q;
  assign load_err  = load_err_q;

`ifdef ALARM_CLOCK_12H_EN
  always_comb begin
    pm = (hours_q >= 5'd12);
    if (hours_q == 5'd0)       disp_hours = 4'd12;
    else if (hours_q <= 5'd12) disp_hours = 4'(hours_q);
    else                       disp_hours = 4'(hours_q - 5'd12);
  end
`endif

endmodule
